// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display arbiter.
package seg_pkg;

  localparam int unsigned DIGITS  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OWNER_W = 3;

  localparam logic [DIGITS-1:0] MASK_ALL  = 8'hFF;
  localparam logic [DIGITS-1:0] MASK_NONE = 8'h00;

  typedef enum logic {
    ARB   = 1'b0,
    DWELL = 1'b1
  } arb_phase_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DIGITS-1:0] mask;
  } disp_word_t;

endpackage

// File: rtl/seg_display_arbiter_rr_arb.sv
// N-way round-robin arbiter: combinational one-hot grant, search starting at ptr_i.
module rr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // First requester at or after ptr_i, wrapping modulo N.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the 8-digit display between N_REQ requesters with a minimum dwell per grant,
// and generates the free-running digit-scan strobe.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = 1000000,
  parameter int unsigned SCAN_DIV    = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic [DIGITS*N_REQ-1:0] req_mask,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       disp_data,
  output logic [DIGITS-1:0]       disp_mask,
  output logic [OWNER_W-1:0]      owner,
  output logic                    owner_valid,
  output logic                    scan_tick
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

  disp_word_t       word_in [N_REQ];
  disp_word_t       word_q, word_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             owner_valid_q, owner_valid_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic             tick_q, tick_d;

  arb_phase_e       phase_c;
  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] win_idx;
  logic             xfer;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign word_in[i].data = req_data[DATA_W*i +: DATA_W];
    assign word_in[i].mask = req_mask[DIGITS*i +: DIGITS];
  end

  assign phase_c = ((hold_q == '0) || !owner_valid_q) ? ARB : DWELL;

  rr_arb #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx)
  );

  // During dwell only the owner may refresh; otherwise round-robin picks the winner.
  always_comb begin
    req_ready = '0;
    if (phase_c == ARB) begin
      req_ready = arb_grant;
    end else begin
      req_ready[owner_q] = req_valid[owner_q];
    end
  end

  assign win_idx = (phase_c == ARB) ? arb_idx : owner_q;
  assign xfer    = |req_ready;

  always_comb begin
    word_d        = word_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    rr_d          = rr_q;
    hold_d        = (hold_q == '0) ? hold_q : hold_q - HOLD_W'(1);
    if (xfer) begin
      word_d        = word_in[win_idx];
      owner_d       = win_idx;
      owner_valid_d = 1'b1;
      hold_d        = HOLD_W'(HOLD_CYCLES);
      // Owner refreshes in dwell leave the round-robin pointer alone.
      if (phase_c == ARB) begin
        rr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end
    end
    scan_d = (scan_q == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_q + SCAN_W'(1);
    tick_d = (scan_d == SCAN_W'(SCAN_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q        <= '{data: '0, mask: MASK_NONE};
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      hold_q        <= '0;
      rr_q          <= '0;
      scan_q        <= '0;
      tick_q        <= 1'b0;
    end else begin
      word_q        <= word_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      hold_q        <= hold_d;
      rr_q          <= rr_d;
      scan_q        <= scan_d;
      tick_q        <= tick_d;
    end
  end

  assign disp_data   = word_q.data;
  assign disp_mask   = word_q.mask;
  assign owner       = OWNER_W'(owner_q);
  assign owner_valid = owner_valid_q;
  assign scan_tick   = tick_q;

endmodule
